// File: rtl/rvm_lsu_pkg.sv
// Shared encodings for the rvm load/store unit: access sizes, error codes,
// FSM states, the registered request record and the alignment predicate.
package rvm_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_SIZE_BYTE = 2'd0,
        LSU_SIZE_HALF = 2'd1,
        LSU_SIZE_WORD = 2'd2,
        LSU_SIZE_ILL  = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_ERR_NONE    = 2'd0,
        LSU_ERR_BUS     = 2'd1,
        LSU_ERR_ALIGN   = 2'd2,
        LSU_ERR_TIMEOUT = 2'd3
    } lsu_err_e;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic        wen;
        lsu_size_e   size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // True when the low address bits cannot be served by a single bus word.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            LSU_SIZE_HALF: bad = addr_lo[0];
            LSU_SIZE_WORD: bad = (addr_lo != 2'b00);
            LSU_SIZE_ILL:  bad = 1'b1;
            default:       bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/rvm_lsu_if.sv
// Request-side (control FSM <-> LSU) and memory-side (LSU <-> bus) interfaces.
// In each, the master modport is the side that initiates the transaction.
interface rvm_lsu_if;
    logic        lsu_req;
    logic        lsu_ready;
    logic        lsu_wen;
    logic [1:0]  lsu_size;
    logic        lsu_signed;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_err;

    modport master (
        output lsu_req, lsu_wen, lsu_size, lsu_signed, lsu_addr, lsu_wdata,
        input  lsu_ready, lsu_done, lsu_rdata, lsu_err
    );
    modport slave (
        input  lsu_req, lsu_wen, lsu_size, lsu_signed, lsu_addr, lsu_wdata,
        output lsu_ready, lsu_done, lsu_rdata, lsu_err
    );
endinterface

interface rvm_mem_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic        mem_c_en;
    logic        mem_w_en;
    logic [3:0]  mem_b_en;
    logic        mem_error;
    logic        mem_stall;

    modport master (
        output mem_addr, mem_wdata, mem_c_en, mem_w_en, mem_b_en,
        input  mem_rdata, mem_error, mem_stall
    );
    modport slave (
        input  mem_addr, mem_wdata, mem_c_en, mem_w_en, mem_b_en,
        output mem_rdata, mem_error, mem_stall
    );
endinterface

// File: rtl/rvm_lsu_lanes.sv
// Combinational byte-lane logic: byte enables, store-data replication and
// load lane selection with sign/zero extension.
module rvm_lsu_lanes
    import rvm_lsu_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        sgn,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  b_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata[8*gi +: 8];
    end

    always_comb begin
        byte_sel  = lane[addr_lo];
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        b_en      = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            LSU_SIZE_BYTE: begin
                b_en      = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sgn & byte_sel[7]}}, byte_sel};
            end
            LSU_SIZE_HALF: begin
                b_en      = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sgn & half_sel[15]}}, half_sel};
            end
            default: begin
                b_en      = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/rvm_lsu.sv
// Load/store unit: registers one request, runs a single bus access with stall
// timeout, and returns extended load data or an error with a one-cycle done.
// Optional build macro: RVM_LSU_ALIGN_CHECK_EN rejects misaligned/illegal requests.
module rvm_lsu
    import rvm_lsu_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       resetn,
    rvm_lsu_if.slave   lsu,
    rvm_mem_if.master  mem
);

    localparam int unsigned CW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;

    lsu_state_e    state_q, state_d;
    lsu_req_t      req_q, req_d;
    logic [CW-1:0] cnt_q, cnt_d;
    lsu_err_e      err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    lsu_size_e   in_size;
    logic [31:0] in_addr;
    logic        reject;
    logic        timeout_hit;
    logic        in_access;
    logic        in_resp;
    logic [3:0]  lane_ben;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

`ifdef RVM_LSU_ALIGN_CHECK_EN
    always_comb begin
        in_size = lsu_size_e'(lsu.lsu_size);
        in_addr = lsu.lsu_addr;
        reject  = lsu_misaligned(lsu.lsu_size, lsu.lsu_addr[1:0]);
    end
`else
    // Without the check, offending low bits are dropped and size 3 acts as a word.
    always_comb begin
        in_size = lsu_size_e'(lsu.lsu_size);
        in_addr = lsu.lsu_addr;
        reject  = 1'b0;
        if (in_size == LSU_SIZE_ILL) begin
            in_size = LSU_SIZE_WORD;
        end
        if (in_size == LSU_SIZE_HALF) begin
            in_addr[0] = 1'b0;
        end else if (in_size == LSU_SIZE_WORD) begin
            in_addr[1:0] = 2'b00;
        end
    end
`endif

    // Abort on the stalled cycle that brings the stall count to STALL_TIMEOUT.
    assign timeout_hit = (STALL_TIMEOUT != 0) && (cnt_q == CW'(STALL_TIMEOUT - 1));

    rvm_lsu_lanes u_lanes (
        .size      (req_q.size),
        .sgn       (req_q.sgn),
        .addr_lo   (req_q.addr[1:0]),
        .wdata     (req_q.wdata),
        .rdata     (mem.mem_rdata),
        .b_en      (lane_ben),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            LSU_IDLE: begin
                if (lsu.lsu_req) begin
                    req_d   = '{wen: lsu.lsu_wen, size: in_size, sgn: lsu.lsu_signed,
                                addr: in_addr, wdata: lsu.lsu_wdata};
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (reject) begin
                        err_d   = LSU_ERR_ALIGN;
                        state_d = LSU_RESP;
                    end else begin
                        err_d   = LSU_ERR_NONE;
                        state_d = LSU_ACCESS;
                    end
                end
            end
            LSU_ACCESS: begin
                if (!mem.mem_stall) begin
                    err_d   = mem.mem_error ? LSU_ERR_BUS : LSU_ERR_NONE;
                    rdata_d = (mem.mem_error || req_q.wen) ? 32'd0 : lane_rdata;
                    state_d = LSU_RESP;
                end else if (timeout_hit) begin
                    err_d   = LSU_ERR_TIMEOUT;
                    rdata_d = '0;
                    state_d = LSU_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_RESP: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= LSU_IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            err_q   <= LSU_ERR_NONE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign in_access = (state_q == LSU_ACCESS);
    assign in_resp   = (state_q == LSU_RESP);

    assign lsu.lsu_ready = (state_q == LSU_IDLE);
    assign lsu.lsu_done  = in_resp;
    assign lsu.lsu_rdata = in_resp ? rdata_q : 32'd0;
    assign lsu.lsu_err   = in_resp ? err_q : LSU_ERR_NONE;

    assign mem.mem_addr  = in_access ? {req_q.addr[31:2], 2'b00} : 32'd0;
    assign mem.mem_wdata = in_access ? lane_wdata : 32'd0;
    assign mem.mem_c_en  = in_access;
    assign mem.mem_w_en  = in_access & req_q.wen;
    assign mem.mem_b_en  = in_access ? lane_ben : 4'd0;

endmodule
